// File: rtl/adder_pkg.sv
// Shared encodings and width default for the bit-serial adder block.
package adder_pkg;

    localparam int ADD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_dataflow.sv
// One-bit full adder cell; the only arithmetic in the serial datapath.
module fa_dataflow (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder controller: feeds fa_dataflow one bit per cycle, LSB first.
// Optional signed-overflow output enabled by defining OVERFLOW_DETECT_EN.
module serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int N = ADD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         co
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic         ovf
`endif
);

    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_sa;
    logic [N-1:0]  r_sb;
    logic [N-1:0]  r_sum_sr;
    logic [N-1:0]  w_sum_sr_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          w_fa_s;
    logic          w_fa_co;
    logic          w_last;

    fa_dataflow u_fa (
        .a  (r_sa[0]),
        .b  (r_sb[0]),
        .ci (r_carry),
        .s  (w_fa_s),
        .co (w_fa_co)
    );

    assign w_last = (r_cnt == LAST);

    // New sum bit enters at the MSB; after N slices bit 0 holds the LSB.
    assign w_sum_sr_nxt = N'({w_fa_s, r_sum_sr} >> 1);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, serial shifting, carry/count and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_sum_sr <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            co       <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
            ovf      <= 1'b0;
`endif
        end else begin
            busy <= (w_state_nxt != ST_IDLE);
            done <= (w_state_nxt == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_carry  <= ci;
                        r_cnt    <= '0;
                        r_sum_sr <= '0;
                    end
                end
                ST_RUN: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_sum_sr <= w_sum_sr_nxt;
                    r_carry  <= w_fa_co;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        sum <= w_sum_sr_nxt;
                        co  <= w_fa_co;
`ifdef OVERFLOW_DETECT_EN
                        // r_carry is the carry into the MSB slice here.
                        ovf <= r_carry ^ w_fa_co;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (N=8 and N=1 instances).
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       co;
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       ci1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       co1;
`ifdef OVERFLOW_DETECT_EN
    logic       ovf;
    logic       ovf1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .co    (co)
`ifdef OVERFLOW_DETECT_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder_ctrl #(.N(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .ci    (ci1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .co    (co1)
`ifdef OVERFLOW_DETECT_EN
        ,
        .ovf   (ovf1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full N=8 operation; operands are scrambled right after capture.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tci, input logic [7:0] es, input logic ec, input logic eo);
        int early;
        early = 0;
        @(negedge clk);
        a = ta; b = tb_v; ci = tci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        a = ~ta; b = ~tb_v; ci = ~tci;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b1) early++;
        end
        chk({tag, "_run"}, 32'(early), 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_co"}, 32'(co), 32'(ec));
`ifdef OVERFLOW_DETECT_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: %s", tag);
`endif
        @(negedge clk);
        chk({tag, "_idle"}, 32'({busy, done}), 32'd0);
        chk({tag, "_hold"}, 32'({co, sum}), 32'({ec, es}));
    endtask

    initial begin
        int cnt_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out", 32'({busy, done, co, sum}), 32'd0);
        chk("reset_out1", 32'({busy1, done1, co1, sum1}), 32'd0);
        rst = 1'b0;

        do_op("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);

        // Abort in the 4th RUN cycle.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out", 32'({busy, done, co, sum}), 32'd0);
        cnt_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt_done++;
        end
        chk("abort_no_done", 32'(cnt_done), 32'd0);

        do_op("add_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // start held high; operands zeroed during RUN.
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        chk("hold_busy", 32'(busy), 32'd1);
        a = 8'h00; b = 8'h00; ci = 1'b0;
        cnt_done = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (done === 1'b1) cnt_done++;
            if (i == 8) begin
                chk("hold_done_at_n", 32'(done), 32'd1);
                chk("hold_sum", 32'({co, sum}), 32'h1FF);
            end
        end
        chk("hold_one_done", 32'(cnt_done), 32'd1);
        chk("hold_gap_idle", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("hold_reaccept", 32'(busy), 32'd1);
        for (int i = 1; i < 8; i++) @(negedge clk);
        @(negedge clk);
        chk("hold2_done", 32'(done), 32'd1);
        chk("hold2_sum", 32'({co, sum}), 32'h000);

        // N=1 instance.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1_busy", 32'({busy1, done1}), 32'd2);
        @(negedge clk);
        chk("n1_done", 32'(done1), 32'd1);
        chk("n1_sum", 32'({co1, sum1}), 32'd3);
`ifdef OVERFLOW_DETECT_EN
        chk("n1_ovf", 32'(ovf1), 32'd0);
`endif
        @(negedge clk);
        chk("n1_idle", 32'({busy1, done1}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
